// File: rtl/delay_timer_pkg.sv
// Shared types and helpers for the queued delay timer: command layout,
// FSM states and the clock-counts-per-unit calculation.
package delay_timer_pkg;

  localparam int CMD_WIDTH = 16;

  typedef struct packed {
    logic                 level;
    logic [CMD_WIDTH-1:0] delay;
  } delay_cmd_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } timer_state_t;

  function automatic int counts_per_unit(input int clk_mhz, input int unit_us);
    return clk_mhz * unit_us;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO with flush; pushed entries are visible at the head
// only from the cycle after the push (no bypass path).
module cmd_fifo #(
  parameter int W     = 17,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign full   = (r_count == CW'(DEPTH));
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign head   = r_mem[r_rd_ptr];
  assign w_push = push && !full && !flush;
  assign w_pop  = pop && !empty && !flush;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= push_data;
  end

endmodule

// File: rtl/queued_delay_timer.sv
// Delay timer fed by a command queue: each command holds level_out for
// delay*COUNTS_PER_UNIT enabled cycles, commands chain with zero gap.
module queued_delay_timer
  import delay_timer_pkg::*;
#(
  parameter int WIDTH          = 16,
  parameter int DEPTH          = 4,
  parameter int UNIT_COUNTS_US = 10,
  parameter int CLK_MHZ        = 8
) (
  input  logic                       clock_in,
  input  logic                       reset_n_in,
  input  logic                       enable_in,
  input  logic                       abort_in,
  input  logic                       cmd_valid_in,
  output logic                       cmd_ready_out,
  input  logic [WIDTH-1:0]           cmd_delay_in,
  input  logic                       cmd_level_in,
  output logic                       busy_out,
  output logic                       level_out,
  output logic                       done_out,
  output logic [$clog2(DEPTH+1)-1:0] fill_out
);

  localparam int COUNTS_PER_UNIT = counts_per_unit(CLK_MHZ, UNIT_COUNTS_US);
  localparam int UW = (COUNTS_PER_UNIT > 1) ? $clog2(COUNTS_PER_UNIT) : 1;
  localparam logic [UW-1:0] UNIT_RELOAD = UW'(COUNTS_PER_UNIT - 1);

  timer_state_t     r_state;
  logic [WIDTH-1:0] r_remaining;
  logic [UW-1:0]    r_unit_cnt;
  logic             r_level;
  logic             r_done;
  logic             r_zero_pend;

  logic [WIDTH:0]   w_head;
  logic [WIDTH-1:0] w_head_delay;
  logic             w_head_level;
  logic             w_empty;
  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic             w_unit_end;
  logic             w_cmd_end;

  assign w_head_delay  = w_head[WIDTH-1:0];
  assign w_head_level  = w_head[WIDTH];
  assign cmd_ready_out = !w_full && !abort_in;
  assign w_push        = cmd_valid_in && cmd_ready_out;
  assign w_unit_end    = (r_unit_cnt == '0);
  assign w_cmd_end     = w_unit_end && (r_remaining <= WIDTH'(1));
  assign w_pop         = enable_in && !abort_in && !w_empty &&
                         (((r_state == IDLE) && !r_zero_pend) ||
                          ((r_state == RUN) && w_cmd_end));

  assign busy_out  = (r_state == RUN);
  assign level_out = r_level;
  assign done_out  = r_done;

  cmd_fifo #(
    .W     (WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_cmd_fifo (
    .clk       (clock_in),
    .rst_n     (reset_n_in),
    .flush     (abort_in),
    .push      (w_push),
    .push_data ({cmd_level_in, cmd_delay_in}),
    .pop       (w_pop),
    .head      (w_head),
    .count     (fill_out),
    .full      (w_full),
    .empty     (w_empty)
  );

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_state     <= IDLE;
      r_remaining <= '0;
      r_unit_cnt  <= '0;
      r_level     <= 1'b0;
      r_done      <= 1'b0;
      r_zero_pend <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (abort_in) begin
        r_state     <= IDLE;
        r_remaining <= '0;
        r_unit_cnt  <= '0;
        r_level     <= 1'b0;
        r_zero_pend <= 1'b0;
      end else if (enable_in) begin
        case (r_state)
          IDLE: begin
            // A zero-delay entry chained behind a completion owes its own pulse.
            if (r_zero_pend) begin
              r_done      <= 1'b1;
              r_zero_pend <= 1'b0;
            end else if (!w_empty) begin
              if (w_head_delay == '0) begin
                r_done <= 1'b1;
              end else begin
                r_state     <= RUN;
                r_remaining <= w_head_delay;
                r_unit_cnt  <= UNIT_RELOAD;
                r_level     <= w_head_level;
              end
            end
          end
          RUN: begin
            if (!w_unit_end) begin
              r_unit_cnt <= r_unit_cnt - UW'(1);
            end else if (!w_cmd_end) begin
              r_remaining <= r_remaining - WIDTH'(1);
              r_unit_cnt  <= UNIT_RELOAD;
            end else begin
              r_done <= 1'b1;
              if (w_empty) begin
                r_state <= IDLE;
                r_level <= 1'b0;
              end else if (w_head_delay == '0) begin
                r_state     <= IDLE;
                r_level     <= 1'b0;
                r_zero_pend <= 1'b1;
              end else begin
                r_remaining <= w_head_delay;
                r_unit_cnt  <= UNIT_RELOAD;
                r_level     <= w_head_level;
              end
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/queued_delay_timer.md
Name: queued_delay_timer

Overview:
Successor delay timer with a parametrised command queue, so delays can be chained back-to-back with zero gap.
- Each command carries a delay in units and an output level to hold during that delay.
- Emits a one-cycle done pulse per completed command.
- Sits between the code-table sequencer and the IR carrier gate, driving mark/space timing.

Parameters:
WIDTH, 16, bit width of a command delay (units).
DEPTH, 4, command queue entries; power of two, at least 2.
UNIT_COUNTS_US, 10, microseconds per delay unit.
CLK_MHZ, 8, clock frequency; COUNTS_PER_UNIT = CLK_MHZ*UNIT_COUNTS_US, at least 1.

Ports:
clock_in  in  1  clock
reset_n_in  in  1  reset, asynchronous, active-low
enable_in  in  1  high = run; low = freeze timing and queue pops (pushes still accepted)
abort_in  in  1  synchronous flush of the queue and the active delay
cmd_valid_in  in  1  command offered
cmd_ready_out  out  1  command accepted on a cycle with valid and ready both high
cmd_delay_in  in  WIDTH  delay in units
cmd_level_in  in  1  level_out value for the duration of this command
busy_out  out  1  a delay is counting
level_out  out  1  level of the active command; 0 when idle
done_out  out  1  one-cycle pulse per completed command
fill_out  out  $clog2(DEPTH+1)  queued entries, excluding the active one

Behaviour:
- Reset (async, active-low): queue empty, state IDLE, busy_out=0, level_out=0, done_out=0, fill_out=0. Counters are cleared.
- cmd_ready_out = (fill_out < DEPTH) && !abort_in. It is combinational, with no bypass: a pushed entry becomes poppable on the next cycle.
- FSM states are IDLE and RUN. Registers:
  - remaining: WIDTH bits.
  - unit_cnt: $clog2(COUNTS_PER_UNIT) bits, minimum 1.
- IDLE, enable_in=1, queue non-empty:
  - Pop the head entry.
  - If delay is 0: stay in IDLE, keep level_out=0, set done_out=1 for the next cycle.
  - Otherwise: go to RUN with remaining=delay, unit_cnt=COUNTS_PER_UNIT-1, level_out=entry level, busy_out=1.
- RUN, enable_in=1:
  - If unit_cnt != 0: decrement it.
  - If unit_cnt == 0 and remaining > 1: decrement remaining and reload unit_cnt.
  - If unit_cnt == 0 and remaining == 1: the command is complete, so done_out=1 next cycle. Then:
    - Queue non-empty: pop the next entry at the same edge (zero-gap chaining; a zero-delay next entry goes to IDLE with its own done pulse the following cycle).
    - Queue empty: go to IDLE with busy_out=0 and level_out=0.
- Timing: busy_out is high for exactly delay*COUNTS_PER_UNIT enabled cycles per command.
- Latency: a push accepted at edge t into an empty, idle timer gives busy_out=1 after edge t+1.
- enable_in=0: unit_cnt, remaining, state and level_out all hold; no pops, no done pulses. Pushes are still accepted.
- Push and pop in the same cycle: fill_out is unchanged. Push while full is impossible because ready is low.
- abort_in=1: takes priority over everything except reset.
  - Next cycle: queue empty, IDLE, busy_out=0, level_out=0, no done pulse.
  - Pushes during abort are refused (ready low).
- Completion coinciding with abort: the abort wins and done_out stays 0.
- Arithmetic is unsigned, with no wrap. remaining is never decremented below 1 in RUN.
- Reset mid-operation: immediate clear to the reset values. Queued commands are lost.

Decomposition:
- Package delay_timer_pkg holds:
  - typedef delay_cmd_t {level, delay[WIDTH-1:0]}, parametrised via a localparam default of 16 (the module recasts as needed);
  - enum timer_state_t {IDLE, RUN};
  - a function for COUNTS_PER_UNIT.
- Sub-module cmd_fifo: synchronous FIFO of delay_cmd_t with DEPTH entries, async active-low reset, flush input, and count/full/empty outputs.
- The FSM and counters stay in queued_delay_timer.

Test Plan:
1. Defaults (COUNTS_PER_UNIT=80): push delay=3, level=1 while idle -> busy_out and level_out high for exactly 240 cycles starting 1 cycle after the handshake. One done_out pulse, then level_out=0, fill_out=0.
2. Back-to-back chaining: push {2,1} then {1,0} -> busy_out continuous for 240 cycles; level_out is 1 for 160 cycles then 0 for 80; done pulses at cycles 161 and 241 after start.
3. Full queue: enable_in=0, offer 5 commands -> 4 accepted, cmd_ready_out low, fill_out=4. Raise enable_in -> all 4 execute in order with zero gaps.
4. Pause: delay=2 running, drop enable_in for 50 cycles at cycle 100 -> busy_out stays high; total busy duration is 210 cycles; done fires once.
5. Abort and zero delay:
   - Abort at cycle 30 of a delay=5 command with 2 entries queued -> next cycle busy=0, level=0, fill=0, no done pulse.
   - Push delay=0 -> one done pulse, busy never rises.
6. Reset: assert reset_n_in low mid-RUN with 3 entries queued -> all outputs 0 asynchronously. After release, cmd_ready_out=1 and fill_out=0.
